// File: rtl/reset_gen.sv
// rtl/reset_gen.sv - merged POR/button/software reset source for the CPU reset_in pin
//
// Ports:
//   clk          system clock, rising edge
//   nreset       asynchronous active-low power-on reset
//   btn_n        raw push-button, active low, asynchronous to clk
//   req_full     software full-reset request, sampled each edge
//   req_special  software special-reset request, sampled each edge
//   M1, T1       sequencer M1 cycle / T1 state indicators
//   reset_out    active-high reset to the CPU
//   busy         high whenever a reset is in progress or armed
//   cause        source of the last reset: 00 POR, 01 button, 10 full, 11 special
//
// Optional feature macro: RESET_GEN_SPECIAL_EN
//   defined   : special reset waits for M1&T1 and emits a one-clock pulse there,
//               escalating to a full reset after SP_TIMEOUT clocks.
//   undefined : req_special acts as req_full; M1/T1 are ignored and reset_out
//               is purely registered.

module reset_gen #(
  parameter int POR_CYCLES      = 16,
  parameter int PULSE_CYCLES    = 3,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int SP_TIMEOUT      = 64
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       btn_n,
  input  logic       req_full,
  input  logic       req_special,
  input  logic       M1,
  input  logic       T1,
  output logic       reset_out,
  output logic       busy,
  output logic [1:0] cause
);

  localparam int CNT_MAX_A = (POR_CYCLES > PULSE_CYCLES) ? POR_CYCLES : PULSE_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > SP_TIMEOUT) ? CNT_MAX_A : SP_TIMEOUT;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int DB_W      = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_POR   = CNT_W'(POR_CYCLES);
  localparam logic [CNT_W-1:0] CNT_PULSE = CNT_W'(PULSE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [DB_W-1:0]  DB_MAX    = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0]  DB_ONE    = DB_W'(1);

  localparam logic [1:0] CAUSE_POR     = 2'b00;
  localparam logic [1:0] CAUSE_BUTTON  = 2'b01;
  localparam logic [1:0] CAUSE_FULL    = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_HOLD    = 2'b01,
    ST_SP_WAIT = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [1:0]       r_cause;
  logic [1:0]       w_cause_next;
  logic             r_rst_hold;

  logic             r_btn_s1;
  logic             r_btn_s2;
  logic [DB_W-1:0]  r_db_cnt;
  logic [DB_W-1:0]  w_db_next;
  logic             w_btn_active;
  logic             w_sp_pulse;

  // Button synchronizer and saturating low-sample counter. Flops reset to the
  // released level so a POR never looks like a press.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_btn_s1 <= 1'b1;
      r_btn_s2 <= 1'b1;
      r_db_cnt <= '0;
    end else begin
      r_btn_s1 <= btn_n;
      r_btn_s2 <= r_btn_s1;
      r_db_cnt <= w_db_next;
    end
  end

  always_comb begin
    w_db_next = r_db_cnt;
    if (r_btn_s2) begin
      w_db_next = '0;
    end else if (r_db_cnt != DB_MAX) begin
      w_db_next = r_db_cnt + DB_ONE;
    end
  end

  // Evaluated on the count the current edge produces, so the press is
  // accepted on the same edge the counter saturates, and it stays asserted
  // (reloading the pulse count) for as long as the button is held.
  assign w_btn_active = (w_db_next == DB_MAX);

`ifdef RESET_GEN_SPECIAL_EN
  localparam logic [CNT_W-1:0] CNT_SP        = CNT_W'(SP_TIMEOUT);
  localparam logic [1:0]       CAUSE_SPECIAL = 2'b11;

  assign w_sp_pulse = (r_state == ST_SP_WAIT) & M1 & T1;
`else
  logic w_unused_m1t1;

  assign w_unused_m1t1 = M1 ^ T1;
  assign w_sp_pulse    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state    <= ST_HOLD;
      r_cnt      <= CNT_POR;
      r_cause    <= CAUSE_POR;
      r_rst_hold <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_cause    <= w_cause_next;
      r_rst_hold <= (w_state_next == ST_HOLD);
    end
  end

  // Next-state logic. Source priority: button > req_full > req_special >
  // the current state's own progress.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_cause_next = r_cause;

    if (w_btn_active) begin
      w_state_next = ST_HOLD;
      w_cnt_next   = CNT_PULSE;
      w_cause_next = CAUSE_BUTTON;
    end else if (req_full) begin
      w_state_next = ST_HOLD;
      w_cnt_next   = CNT_PULSE;
      w_cause_next = CAUSE_FULL;
`ifdef RESET_GEN_SPECIAL_EN
    end else if (req_special && (r_state == ST_IDLE)) begin
      w_state_next = ST_SP_WAIT;
      w_cnt_next   = CNT_SP;
      w_cause_next = CAUSE_SPECIAL;
`else
    end else if (req_special) begin
      w_state_next = ST_HOLD;
      w_cnt_next   = CNT_PULSE;
      w_cause_next = CAUSE_FULL;
`endif
    end else begin
      case (r_state)
        ST_HOLD: begin
          if (r_cnt > CNT_ONE) begin
            w_cnt_next = r_cnt - CNT_ONE;
          end else begin
            // Count exhausted; park at zero until the synchronized button
            // is seen released.
            w_cnt_next = '0;
            if (r_btn_s2) begin
              w_state_next = ST_IDLE;
            end
          end
        end
`ifdef RESET_GEN_SPECIAL_EN
        ST_SP_WAIT: begin
          if (M1 && T1) begin
            // The pulse is emitted combinationally this cycle; close it here.
            w_state_next = ST_IDLE;
          end else if (r_cnt <= CNT_ONE) begin
            w_state_next = ST_HOLD;
            w_cnt_next   = CNT_PULSE;
            w_cause_next = CAUSE_FULL;
          end else begin
            w_cnt_next = r_cnt - CNT_ONE;
          end
        end
`endif
        default: begin
          w_state_next = r_state;
        end
      endcase
    end
  end

  assign reset_out = r_rst_hold | w_sp_pulse;
  assign busy      = (r_state != ST_IDLE);
  assign cause     = r_cause;

endmodule

// File: tb/tb_reset_gen.sv
// tb/tb_reset_gen.sv - self-checking bench for reset_gen

module tb_reset_gen;

  localparam int POR   = 16;
  localparam int PULSE = 3;
  localparam int DEB   = 8;
  localparam int SPT   = 64;
`ifdef RESET_GEN_SPECIAL_EN
  localparam bit SPECIAL = 1'b1;
`else
  localparam bit SPECIAL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       btn_n = 1'b1;
  logic       req_full = 1'b0;
  logic       req_special = 1'b0;
  logic       M1 = 1'b0;
  logic       T1 = 1'b0;
  logic       reset_out;
  logic       busy;
  logic [1:0] cause;

  int checks = 0;
  int errors = 0;
  int total_hi = 0;
  int base = 0;

  reset_gen #(
    .POR_CYCLES      (POR),
    .PULSE_CYCLES    (PULSE),
    .DEBOUNCE_CYCLES (DEB),
    .SP_TIMEOUT      (SPT)
  ) dut (
    .clk         (clk),
    .nreset      (nreset),
    .btn_n       (btn_n),
    .req_full    (req_full),
    .req_special (req_special),
    .M1          (M1),
    .T1          (T1),
    .reset_out   (reset_out),
    .busy        (busy),
    .cause       (cause)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: actual %0d required %0d", name, $time, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Behavioural model: timestamps rather than down-counters. m_e numbers the
  // rising edges since the last POR release; a full reset started at edge s
  // ends at edge s+len (provided the synchronized button is up), a special
  // reset armed at edge s escalates at edge s+SPT.
  localparam int K_IDLE = 0;
  localparam int K_HOLD = 1;
  localparam int K_SP   = 2;

  int   m_e = 0;
  int   m_kind = K_HOLD;
  int   m_end = POR;
  int   m_sp_start = 0;
  int   m_cause = 0;
  bit   hist[$];

  always @(posedge clk or negedge nreset) begin
    bit s2_old;
    bit deb;
    if (!nreset) begin
      m_e = 0;
      hist.delete();
      m_kind = K_HOLD;
      m_end = POR;
      m_cause = 0;
    end else begin
      m_e++;
      hist.push_back(btn_n);
      // Sample taken at edge j lives in hist[j-1]; two flops of delay.
      s2_old = (m_e >= 3) ? hist[m_e-3] : 1'b1;
      deb = (m_e >= DEB + 2);
      for (int i = 0; i < DEB; i++) begin
        if (deb && hist[m_e-3-i]) deb = 1'b0;
      end
      if (deb) begin
        m_kind = K_HOLD; m_end = m_e + PULSE; m_cause = 1;
      end else if (req_full || (!SPECIAL && req_special)) begin
        m_kind = K_HOLD; m_end = m_e + PULSE; m_cause = 2;
      end else if (SPECIAL && req_special && m_kind == K_IDLE) begin
        m_kind = K_SP; m_sp_start = m_e; m_cause = 3;
      end else if (m_kind == K_HOLD) begin
        if (m_e >= m_end && s2_old) m_kind = K_IDLE;
      end else if (m_kind == K_SP) begin
        if (M1 && T1) begin
          m_kind = K_IDLE;
        end else if (m_e >= m_sp_start + SPT) begin
          m_kind = K_HOLD; m_end = m_e + PULSE; m_cause = 2;
        end
      end
    end
  end

  // Compare process, mid-cycle.
  always @(negedge clk) begin
    int exp_rst;
    int exp_busy;
    int exp_cause;
    if (!nreset) begin
      exp_rst = 1; exp_busy = 1; exp_cause = 0;
    end else begin
      exp_rst   = (m_kind == K_HOLD || (m_kind == K_SP && M1 && T1)) ? 1 : 0;
      exp_busy  = (m_kind != K_IDLE) ? 1 : 0;
      exp_cause = m_cause;
    end
    chk("reset_out", int'(reset_out), exp_rst);
    chk("busy", int'(busy), exp_busy);
    chk("cause", int'(cause), exp_cause);
    if (reset_out) total_hi++;
  end

  initial begin
    // POR: 5 clocks low, then 16 edges of reset.
    tick(5);
    nreset = 1'b1;
    base = total_hi;
    tick(20);
    chk("por_width", total_hi - base, 16);
    chk("por_cause", int'(cause), 0);
    chk("por_busy", int'(busy), 0);

    // Single software full reset.
    base = total_hi;
    req_full = 1'b1;
    tick(1);
    req_full = 1'b0;
    tick(9);
    chk("full_width", total_hi - base, 3);
    chk("full_cause", int'(cause), 2);

    // Second request one edge later extends to 4.
    base = total_hi;
    req_full = 1'b1;
    tick(2);
    req_full = 1'b0;
    tick(8);
    chk("full_ext_width", total_hi - base, 4);

`ifdef RESET_GEN_SPECIAL_EN
    // Special reset aligned to M1&T1 on the 4th following cycle.
    base = total_hi;
    req_special = 1'b1;
    tick(1);
    req_special = 1'b0;
    M1 = 1'b1;
    tick(1);
    M1 = 1'b0;
    tick(2);
    M1 = 1'b1; T1 = 1'b1;
    tick(1);
    M1 = 1'b0; T1 = 1'b0;
    tick(5);
    chk("sp_width", total_hi - base, 1);
    chk("sp_cause", int'(cause), 3);
    chk("sp_busy", int'(busy), 0);

    // Special reset timeout escalates to a full reset.
    req_special = 1'b1;
    tick(1);
    req_special = 1'b0;
    base = total_hi;
    tick(63);
    chk("sp_to_quiet", total_hi - base, 0);
    base = total_hi;
    tick(10);
    chk("sp_to_width", total_hi - base, 3);
    chk("sp_to_cause", int'(cause), 2);
`else
    // Without the special path, req_special is a full reset.
    base = total_hi;
    req_special = 1'b1;
    tick(1);
    req_special = 1'b0;
    tick(9);
    chk("spx_width", total_hi - base, 3);
    chk("spx_cause", int'(cause), 2);
`endif

    // Button glitch of 5 clocks: no reset.
    base = total_hi;
    btn_n = 1'b0;
    tick(5);
    btn_n = 1'b1;
    tick(12);
    chk("btn_glitch", total_hi - base, 0);

    // Button held 20 clocks: rises after edge 10, falls 3 edges after sync release.
    base = total_hi;
    btn_n = 1'b0;
    tick(10);
    chk("btn_early", total_hi - base, 0);
    base = total_hi;
    tick(10);
    btn_n = 1'b1;
    tick(10);
    chk("btn_width", total_hi - base, 15);
    chk("btn_cause", int'(cause), 1);
    chk("btn_busy", int'(busy), 0);

    // POR asserted mid-operation.
    req_special = 1'b1;
    tick(1);
    req_special = 1'b0;
    tick(2);
    nreset = 1'b0;
    #1;
    chk("mid_por_rst", int'(reset_out), 1);
    chk("mid_por_cause", int'(cause), 0);
    chk("mid_por_busy", int'(busy), 1);
    tick(3);
    nreset = 1'b1;
    tick(20);
    M1 = 1'b1; T1 = 1'b1;
    #2;
    chk("mid_por_after_rst", int'(reset_out), 0);
    chk("mid_por_after_cause", int'(cause), 0);
    chk("mid_por_after_busy", int'(busy), 0);
    M1 = 1'b0; T1 = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
